// File: rtl/vfp_config_sequencer.sv
// Configuration sequencer: walks a table of (address, data) entries, writes each
// one over AXI4-Lite, then reads back a single status register.
module vfp_config_sequencer #(
    parameter int unsigned NUM_ENTRIES = 16,
    parameter logic [7:0]  STATUS_ADDR = 8'h00,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic                           ACLK,
    input  logic                           reset,
    input  logic                           start,
    output logic [$clog2(NUM_ENTRIES)-1:0] tbl_idx,
    input  logic [7:0]                     tbl_addr,
    input  logic [31:0]                    tbl_data,
    input  logic                           tbl_last,
    output logic [7:0]                     AWADDR,
    output logic [2:0]                     AWPROT,
    output logic                           AWVALID,
    input  logic                           AWREADY,
    output logic [31:0]                    WDATA,
    output logic [3:0]                     WSTRB,
    output logic                           WVALID,
    input  logic                           WREADY,
    input  logic [1:0]                     BRESP,
    input  logic                           BVALID,
    output logic                           BREADY,
    output logic [7:0]                     ARADDR,
    output logic [2:0]                     ARPROT,
    output logic                           ARVALID,
    input  logic                           ARREADY,
    input  logic [31:0]                    RDATA,
    input  logic [1:0]                     RRESP,
    input  logic                           RVALID,
    output logic                           RREADY,
    output logic                           busy,
    output logic                           done,
    output logic                           error,
    output logic [31:0]                    status
);

    localparam int unsigned     IdxW     = $clog2(NUM_ENTRIES);
    localparam int unsigned     CntW     = $clog2(TIMEOUT + 1);
    localparam logic [IdxW-1:0] LastIdx  = IdxW'(NUM_ENTRIES - 1);
    // Last cycle a phase may occupy before it is abandoned.
    localparam logic [CntW-1:0] CntLimit = CntW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StWaddr,
        StWresp,
        StRaddr,
        StRdata,
        StDone,
        StErr
    } state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            aw_done_q, aw_done_d;
    logic            w_done_q, w_done_d;
    logic            error_q, error_d;
    logic [31:0]     status_q, status_d;

    logic aw_acc;
    logic w_acc;
    logic timed_out;
    logic timed_state;

    // Next-state, table index, handshake bookkeeping and status capture.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        error_d   = error_q;
        status_d  = status_q;
        aw_acc    = aw_done_q | (AWVALID & AWREADY);
        w_acc     = w_done_q | (WVALID & WREADY);
        timed_out = (cnt_q == CntLimit);

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    idx_d     = '0;
                    error_d   = 1'b0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = StWaddr;
                end
            end
            StWaddr: begin
                aw_done_d = aw_acc;
                w_done_d  = w_acc;
                if (aw_acc && w_acc) begin
                    state_d = StWresp;
                end else if (timed_out) begin
                    state_d = StErr;
                end
            end
            StWresp: begin
                if (BVALID) begin
                    if (BRESP != 2'b00) begin
                        state_d = StErr;
                    end else if (tbl_last || (idx_q == LastIdx)) begin
                        state_d = StRaddr;
                    end else begin
                        idx_d     = idx_q + IdxW'(1);
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        state_d   = StWaddr;
                    end
                end else if (timed_out) begin
                    state_d = StErr;
                end
            end
            StRaddr: begin
                if (ARREADY) begin
                    state_d = StRdata;
                end else if (timed_out) begin
                    state_d = StErr;
                end
            end
            StRdata: begin
                if (RVALID) begin
                    if (RRESP == 2'b00) begin
                        status_d = RDATA;
                        state_d  = StDone;
                    end else begin
                        state_d = StErr;
                    end
                end else if (timed_out) begin
                    state_d = StErr;
                end
            end
            StDone:  state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // error is visible in the same cycle as the ERR completion pulse
        if (state_d == StErr) begin
            error_d = 1'b1;
        end
    end

    // Per-phase cycle counter, cleared on every state entry.
    always_comb begin
        timed_state = (state_q == StWaddr) || (state_q == StWresp) ||
                      (state_q == StRaddr) || (state_q == StRdata);
        if ((state_d != state_q) || !timed_state) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge ACLK) begin
        if (reset) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            cnt_q     <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            error_q   <= 1'b0;
            status_q  <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            error_q   <= error_d;
            status_q  <= status_d;
        end
    end

    // Bus outputs decoded from registered state; payloads read as zero when idle.
    always_comb begin
        AWVALID = (state_q == StWaddr) && !aw_done_q;
        WVALID  = (state_q == StWaddr) && !w_done_q;
        BREADY  = (state_q == StWresp);
        ARVALID = (state_q == StRaddr);
        RREADY  = (state_q == StRdata);
        AWADDR  = AWVALID ? tbl_addr : 8'h00;
        WDATA   = WVALID ? tbl_data : 32'h0;
        ARADDR  = ARVALID ? STATUS_ADDR : 8'h00;
        AWPROT  = 3'b000;
        ARPROT  = 3'b000;
        WSTRB   = 4'hF;
        busy    = (state_q == StWaddr) || (state_q == StWresp) ||
                  (state_q == StRaddr) || (state_q == StRdata);
        done    = (state_q == StDone) || (state_q == StErr);
        error   = error_q;
        status  = status_q;
        tbl_idx = idx_q;
    end

endmodule

// File: doc/vfp_config_sequencer.md
VFP_CONFIG_SEQUENCER -- requirements
Module: vfp_config_sequencer

Interface
REQ-001 SHALL have parameter NUM_ENTRIES, default 16: maximum entries in the configuration table (power of two, 2..256).
REQ-002 SHALL have parameter STATUS_ADDR, default 8'h00: AXI4-Lite address read back after the last write.
REQ-003 SHALL have parameter TIMEOUT, default 255: maximum cycles to wait for any single handshake phase.
REQ-004 SHALL use a single clock: ACLK  in  1  all logic on rising edge.
REQ-005 SHALL use a synchronous, active-high reset: reset  in  1  sampled on the rising edge of ACLK.
REQ-006 start  in  1  one-cycle request to run the table; ignored while busy=1.
REQ-007 tbl_idx  out  clog2(NUM_ENTRIES)  index of the current table entry.
REQ-008 tbl_addr  in  8, tbl_data  in  32, tbl_last  in  1  combinational table contents at tbl_idx.
REQ-009 AWADDR out 8, AWPROT out 3, AWVALID out 1, AWREADY in 1  AXI4-Lite write address channel.
REQ-010 WDATA out 32, WSTRB out 4, WVALID out 1, WREADY in 1  AXI4-Lite write data channel.
REQ-011 BRESP in 2, BVALID in 1, BREADY out 1  AXI4-Lite write response channel.
REQ-012 ARADDR out 8, ARPROT out 3, ARVALID out 1, ARREADY in 1  AXI4-Lite read address channel.
REQ-013 RDATA in 32, RRESP in 2, RVALID in 1, RREADY out 1  AXI4-Lite read data channel.
REQ-014 busy out 1, done out 1, error out 1, status out 32  sequencer status and read-back value.

Function
REQ-015 SHALL implement states IDLE, WADDR, WRESP, RADDR, RDATA, DONE, ERR.
REQ-016 IDLE: on start=1, SHALL set tbl_idx=0, clear error, set busy=1 and enter WADDR next cycle.
REQ-017 WADDR: SHALL assert AWVALID and WVALID together, with AWADDR=tbl_addr, WDATA=tbl_data, WSTRB=4'hF and AWPROT=0.
REQ-018 SHALL drop each of AWVALID and WVALID independently in the cycle after its own VALID&READY; SHALL enter WRESP once both channels have been accepted, including when both are accepted in the same cycle.
REQ-019 SHALL hold AWADDR and WDATA stable while the corresponding VALID is high.
REQ-020 WRESP: SHALL assert BREADY, and SHALL leave WRESP when BVALID=1.
REQ-021 On BVALID=1 with BRESP!=2'b00, SHALL go to ERR.
REQ-022 On BVALID=1 with BRESP=2'b00 and tbl_last=0 and tbl_idx<NUM_ENTRIES-1, SHALL increment tbl_idx and return to WADDR.
REQ-023 On BVALID=1 with BRESP=2'b00 and (tbl_last=1 or tbl_idx=NUM_ENTRIES-1), SHALL go to RADDR; tbl_idx SHALL NOT wrap.
REQ-024 RADDR: SHALL assert ARVALID with ARADDR=STATUS_ADDR and ARPROT=0; on ARREADY=1, SHALL go to RDATA.
REQ-025 RDATA: SHALL assert RREADY; on RVALID=1 with RRESP=2'b00, SHALL capture RDATA into status and go to DONE; on RVALID=1 with RRESP!=2'b00, SHALL go to ERR.
REQ-026 DONE: SHALL pulse done=1 for exactly one cycle, clear busy and return to IDLE.
REQ-027 ERR: SHALL set error=1 (sticky until the next accepted start), pulse done=1 for one cycle, clear busy, return to IDLE, and leave status unchanged.
REQ-028 SHALL count cycles spent in each of WADDR, WRESP, RADDR and RDATA, and SHALL reset the counter on every state entry.
REQ-029 SHALL go to ERR on the cycle the state counter reaches TIMEOUT, dropping all VALID/READY outputs.
REQ-030 Latency with zero-wait slave: 2 cycles per write entry (WADDR, WRESP), plus 2 read cycles, plus 1 DONE cycle.

Reset
REQ-031 On reset=1, SHALL set: state=IDLE, tbl_idx=0, all VALID/READY outputs=0, AWADDR=0, WDATA=0, ARADDR=0, WSTRB=4'hF, AWPROT=ARPROT=0, busy=0, done=0, error=0, status=0.
REQ-032 Reset mid-transaction SHALL abort immediately with no completion pulse; the next start SHALL restart at entry 0.

Verification
REQ-033 3-entry table {(0x04,0x11),(0x08,0x22),(0x0C,0x33,last)}, zero-wait slave, RDATA=0xA5 -> three writes in order, status=0xA5, done after 9 cycles, error=0.
REQ-034 AWREADY delayed 3 cycles, WREADY immediate -> WVALID low after 1 cycle, AWVALID held stable 3 cycles, single BREADY phase, sequence completes.
REQ-035 Entry 1 returns BRESP=2'b10 -> no write of entry 2, no AR issued, error=1, done pulse, status=0.
REQ-036 TIMEOUT=8, BVALID never asserted -> ERR 8 cycles after entering WRESP, BREADY=0 afterwards, error=1.
REQ-037 start pulsed while busy -> ignored; reset asserted during WRESP, then start -> tbl_idx=0, first AWADDR=0x04.
REQ-038 No tbl_last, NUM_ENTRIES=4 -> exactly 4 writes, tbl_idx stops at 3, then read-back.
